// File: rtl/timestamp_arbiter.sv
// ----------------------------------------------------------------------------
// timestamp_arbiter : per-port timestamp FIFOs merged round-robin onto one
//                     valid/ready stream. Optional drop counters: TS_ARB_DROP_CNT_EN
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module timestamp_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_BITS      = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS*64-1:0]             in_timestamp,
  input  logic [NUM_PORTS-1:0]                in_valid,
  output logic [63:0]                         out_timestamp,
  output logic [PORT_BITS-1:0]                out_port,
  output logic                                out_valid,
  input  logic                                out_rdy,
  input  logic                                drop_clr,
  output logic [NUM_PORTS*DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_PORTS-1:0]        full_w;
  logic [NUM_PORTS-1:0]        nempty_w;
  logic [NUM_PORTS-1:0]        pop_w;
  logic [NUM_PORTS-1:0][63:0]  head_w;

  logic                        found_w;
  logic                        load_w;
  logic [PORT_BITS-1:0]        grant_w;
  logic [NUM_PORTS-1:0]        grant_oh_w;
  logic [63:0]                 grant_ts_w;

  logic [63:0]                 out_ts_q;
  logic [PORT_BITS-1:0]        out_port_q;
  logic                        out_valid_q;
  logic [PORT_BITS-1:0]        last_grant_q;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
      logic [63:0]   mem_q [FIFO_DEPTH];
      logic [AW-1:0] wr_ptr_q;
      logic [AW-1:0] rd_ptr_q;
      logic [CW-1:0] cnt_q;
      logic          push_w;

      // Full is judged on start-of-cycle occupancy, so a same-cycle pop never rescues a write.
      assign full_w[p]   = (cnt_q == CW'(FIFO_DEPTH));
      assign nempty_w[p] = (cnt_q != '0);
      assign push_w      = in_valid[p] && !full_w[p];
      assign head_w[p]   = mem_q[rd_ptr_q];

      always_ff @(posedge clk) begin
        if (push_w) begin
          mem_q[wr_ptr_q] <= in_timestamp[64*p +: 64];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          if (push_w) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
          if (pop_w[p]) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
          if (push_w && !pop_w[p]) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (!push_w && pop_w[p]) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      end
    end
  endgenerate

  // Round-robin search starting one past the last granted port.
  always_comb begin
    int idx;
    found_w    = 1'b0;
    grant_w    = '0;
    grant_oh_w = '0;
    grant_ts_w = '0;
    idx        = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_PORTS;
      if (!found_w && nempty_w[idx]) begin
        found_w         = 1'b1;
        grant_w         = PORT_BITS'(idx);
        grant_oh_w[idx] = 1'b1;
        grant_ts_w      = head_w[idx];
      end
    end
  end

  assign load_w = (!out_valid_q || out_rdy) && found_w;
  assign pop_w  = grant_oh_w & {NUM_PORTS{load_w}};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ts_q     <= '0;
      out_port_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= PORT_BITS'(NUM_PORTS - 1);
    end else if (load_w) begin
      out_ts_q     <= grant_ts_w;
      out_port_q   <= grant_w;
      out_valid_q  <= 1'b1;
      last_grant_q <= grant_w;
    end else if (out_rdy) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_timestamp = out_ts_q;
  assign out_port      = out_port_q;
  assign out_valid     = out_valid_q;

`ifdef TS_ARB_DROP_CNT_EN
  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_drop
      logic [DROP_CNT_WIDTH-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (reset || drop_clr) begin
          cnt_q <= '0;
        end else if (in_valid[p] && full_w[p] && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign drop_cnt[DROP_CNT_WIDTH*p +: DROP_CNT_WIDTH] = cnt_q;
    end
  endgenerate
`else
  logic unused_drop_clr_w;
  assign unused_drop_clr_w = drop_clr;
  assign drop_cnt          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timestamp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_timestamp_arbiter : scoreboard bench for timestamp_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_timestamp_arbiter;

  localparam int NP = 4;
  localparam int PB = 2;
  localparam int DW = 4;

  logic              clk;
  logic              reset;
  logic [NP*64-1:0]  in_timestamp;
  logic [NP-1:0]     in_valid;
  logic [63:0]       out_timestamp;
  logic [PB-1:0]     out_port;
  logic              out_valid;
  logic              out_rdy;
  logic              drop_clr;
  logic [NP*DW-1:0]  drop_cnt;

  typedef struct packed {
    logic [63:0]   ts;
    logic [PB-1:0] port;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  timestamp_arbiter #(
    .NUM_PORTS(NP), .PORT_BITS(PB), .FIFO_DEPTH(4), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .in_timestamp(in_timestamp), .in_valid(in_valid),
    .out_timestamp(out_timestamp), .out_port(out_port), .out_valid(out_valid),
    .out_rdy(out_rdy), .drop_clr(drop_clr), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NP-1:0] mask, input logic [63:0] t0, input logic [63:0] t1,
                       input logic [63:0] t2, input logic [63:0] t3);
    in_timestamp = {t3, t2, t1, t0};
    in_valid     = mask;
    tick();
    in_valid     = '0;
  endtask

  task automatic push_exp(input logic [63:0] ts, input logic [PB-1:0] port);
    exp_t e;
    e.ts   = ts;
    e.port = port;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check_eq("drain_left", 64'(exp_q.size()), 0);
    tick();
  endtask

  // Every handshake on the output is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {out_port, out_timestamp[31:0]}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("mon_ts", out_timestamp, mon_e.ts);
        check_eq("mon_port", 64'(out_port), 64'(mon_e.port));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP*DW-1:0] exp_drop;
    logic [63:0]      a_ts;

    reset        = 1'b1;
    in_timestamp = '0;
    in_valid     = '0;
    out_rdy      = 1'b1;
    drop_clr     = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 64'(out_valid), 0);
    check_eq("rst_ts", out_timestamp, 0);
    check_eq("rst_port", 64'(out_port), 0);
    check_eq("rst_drop", 64'(drop_cnt), 0);
    reset = 1'b0;
    tick();

    // Single event on port 2, two-cycle latency, one-cycle valid.
    push_exp(64'h0000_0001_0000_00AA, 2);
    drive(4'b0100, 0, 0, 64'h0000_0001_0000_00AA, 0);
    check_eq("single_n1_valid", 64'(out_valid), 0);
    tick();
    check_eq("single_valid", 64'(out_valid), 1);
    check_eq("single_ts", out_timestamp, 64'h0000_0001_0000_00AA);
    check_eq("single_port", 64'(out_port), 2);
    tick();
    check_eq("single_after", 64'(out_valid), 0);
    drain();

    // Reset again so round-robin starts from port 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    for (int p = 0; p < NP; p++) push_exp(64'h10 + 64'(p), PB'(p));
    drive(4'b1111, 64'h10, 64'h11, 64'h12, 64'h13);
    for (int p = 0; p < NP; p++) begin
      tick();
      check_eq("rr_valid", 64'(out_valid), 1);
      check_eq("rr_port", 64'(out_port), 64'(p));
    end
    tick();
    check_eq("rr_idle", 64'(out_valid), 0);

    push_exp(64'h21, 1);
    push_exp(64'h23, 3);
    drive(4'b1010, 0, 64'h21, 0, 64'h23);
    tick();
    check_eq("rr2_first", 64'(out_port), 1);
    tick();
    check_eq("rr2_second", 64'(out_port), 3);
    drain();

    // Backpressure: A held while out_rdy low, then A,B,C back to back.
    out_rdy = 1'b0;
    a_ts    = 64'hA000_0000_0000_000A;
    push_exp(a_ts, 0);
    push_exp(64'hB0B, 0);
    push_exp(64'hC0C, 0);
    drive(4'b0001, a_ts, 0, 0, 0);
    drive(4'b0001, 64'hB0B, 0, 0, 0);
    drive(4'b0001, 64'hC0C, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_hold_valid", 64'(out_valid), 1);
      check_eq("bp_hold_ts", out_timestamp, a_ts);
      tick();
    end
    out_rdy = 1'b1;
    check_eq("bp_a", out_timestamp, a_ts);
    tick();
    check_eq("bp_b_valid", 64'(out_valid), 1);
    check_eq("bp_b", out_timestamp, 64'hB0B);
    tick();
    check_eq("bp_c_valid", 64'(out_valid), 1);
    check_eq("bp_c", out_timestamp, 64'hC0C);
    tick();
    check_eq("bp_idle", 64'(out_valid), 0);
    drain();

    // Overflow on port 1: 7 pulses, 5 stored, 2 dropped.
    out_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) push_exp(64'h100 + 64'(i), 1);
      drive(4'b0010, 0, 64'h100 + 64'(i), 0, 0);
    end
`ifdef TS_ARB_DROP_CNT_EN
    exp_drop = 16'h0020;
`else
    exp_drop = 16'h0000;
`endif
    check_eq("ovf_drop", 64'(drop_cnt), 64'(exp_drop));
    out_rdy = 1'b1;
    drain();

    // Saturation on port 3 (20 drops), then clear racing a further drop.
    out_rdy = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) push_exp(64'h300 + 64'(i), 3);
      drive(4'b1000, 0, 0, 0, 64'h300 + 64'(i));
    end
`ifdef TS_ARB_DROP_CNT_EN
    exp_drop = 16'hF020;
`else
    exp_drop = 16'h0000;
`endif
    check_eq("sat_drop", 64'(drop_cnt), 64'(exp_drop));
    drop_clr = 1'b1;
    drive(4'b1000, 0, 0, 0, 64'h3FF);
    drop_clr = 1'b0;
    check_eq("clr_drop", 64'(drop_cnt), 0);
    out_rdy = 1'b1;
    drain();

    // Mid-stream reset discards the held entry and queued FIFO data.
    out_rdy = 1'b0;
    drive(4'b0101, 64'h400, 0, 64'h402, 0);
    drive(4'b0101, 64'h410, 0, 64'h412, 0);
    check_eq("mr_pre_valid", 64'(out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mr_valid", 64'(out_valid), 0);
    check_eq("mr_ts", out_timestamp, 0);
    check_eq("mr_port", 64'(out_port), 0);
    check_eq("mr_drop", 64'(drop_cnt), 0);
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("mr_no_stale", 64'(out_valid), 0);
    push_exp(64'h501, 1);
    drive(4'b0010, 0, 64'h501, 0, 0);
    tick();
    check_eq("mr_next_port", 64'(out_port), 1);
    check_eq("mr_next_ts", out_timestamp, 64'h501);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timestamp_arbiter.md
# timestamp_arbiter

Merges the per-port RX timestamp streams produced by the NetFPGA MAC groups into one timestamp stream for the monitor datapath. Each MAC group emits a 64-bit timestamp with a single-cycle valid pulse and cannot be stalled. This block buffers each port in a small FIFO, grants the ports round-robin, and presents one tagged timestamp per transfer on a valid/ready output. Per-port overflow drop counters are an optional feature.

## Interface
Parameters:
- NUM_PORTS, 4, number of MAC group timestamp sources.
- PORT_BITS, 2, width of the port tag. Must satisfy 2^PORT_BITS >= NUM_PORTS.
- FIFO_DEPTH, 4, entries per port FIFO. Must be a power of 2 and at least 2.
- DROP_CNT_WIDTH, 16, width of each drop counter.

Ports:
- clk  in  1  single clock; all logic is in this domain.
- reset  in  1  synchronous, active-high.
- in_timestamp  in  NUM_PORTS*64  per-port timestamp. Port p occupies bits [64p+63:64p].
- in_valid  in  NUM_PORTS  per-port single-cycle valid pulse. No backpressure is applied to the sources.
- out_timestamp  out  64  granted timestamp.
- out_port  out  PORT_BITS  index of the source port for out_timestamp.
- out_valid  out  1  output holds a valid entry.
- out_rdy  in  1  consumer accepts the entry.
- drop_clr  in  1  pulse that clears all drop counters.
- drop_cnt  out  NUM_PORTS*DROP_CNT_WIDTH  per-port count of timestamps dropped on overflow.

## Operation
Per-port FIFOs:
- Each port has a FIFO_DEPTH-entry FIFO.
- When in_valid[p]=1, the timestamp is written to FIFO p unless that FIFO is full.
- "Full" is evaluated on the occupancy at the start of the cycle. A write to a full FIFO is dropped even if the same FIFO is popped in that cycle.
- Read and write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a counter of width log2(FIFO_DEPTH)+1.

Output register and arbiter:
- There is a single output register: out_timestamp, out_port, out_valid.
- The register loads when (!out_valid || out_rdy) and at least one FIFO is non-empty. The FIFO is popped in the same cycle.
- If the load condition holds but all FIFOs are empty, out_valid deasserts after the transfer.
- Arbitration is round-robin. A pointer last_grant records the last granted port. The search order is last_grant+1, last_grant+2, … (mod NUM_PORTS), and the first non-empty FIFO wins.
- last_grant updates only on a load.
- On reset, last_grant is set to NUM_PORTS-1, so port 0 has first priority.

Drop counters:
- drop_cnt[p] increments by 1 on each dropped write and saturates at all-ones.
- drop_clr has priority over an increment in the same cycle; the result is 0.

Reset:
- Reset empties all FIFOs.
- All outputs reset to 0: out_valid, out_timestamp, out_port, drop_cnt.
- An entry held in the output register when reset asserts mid-transfer is discarded. No partial state survives.

## Timing
- Latency: in_valid[p] in cycle N gives out_valid in cycle N+2 when the output register is free and no other port wins the arbitration.
- The FIFO write completes at the end of cycle N, the output register loads at the end of cycle N+1, and the entry is visible in cycle N+2.
- Throughput: one entry per cycle while out_rdy=1 (back-to-back loads).
- Handshake: while out_valid=1 and out_rdy=0, out_timestamp and out_port hold stable.
- A transfer occurs on any cycle with out_valid && out_rdy.
- Simultaneous pulses on all ports in one cycle are all stored if the FIFOs have room, then drained in round-robin order.

## Configuration
- TS_ARB_DROP_CNT_EN defined: the drop counters are implemented as described.
- TS_ARB_DROP_CNT_EN undefined: no counter logic is built, drop_cnt is tied to 0, and drop_clr is ignored.
- Drop behaviour (writes to a full FIFO are discarded) is identical in both builds.

## Test plan
- Single event: after reset with out_rdy=1, pulse in_valid[2] with 64'h0000_0001_0000_00AA. Expect out_valid=1 two cycles later with out_timestamp=64'h0000_0001_0000_00AA and out_port=2, for exactly one cycle.
- Round-robin order: after reset, pulse all 4 ports in the same cycle with timestamps 0x10, 0x11, 0x12 and 0x13 (port 0 to port 3), with out_rdy=1. Expect out_port sequence 0,1,2,3 on consecutive cycles. Then pulse ports 1 and 3 together; expect order 1,3 (last_grant was 3).
- Backpressure: hold out_rdy=0 while pulsing port 0 three times with values A, B, C. Expect out_timestamp=A held stable. Release out_rdy and expect A, B, C on consecutive cycles with no gaps.
- Overflow: hold out_rdy=0 and pulse port 1 seven times. The output register takes 1 entry and the FIFO takes 4, so 5 are stored. Expect drop_cnt[1]=2 and the other counters 0. Drain and check 5 ordered entries.
- Saturation and clear (TS_ARB_DROP_CNT_EN defined): with DROP_CNT_WIDTH=4, force 20 drops on port 3. Expect drop_cnt[3]=4'hF. Pulse drop_clr in the same cycle as a further drop; expect 0.
- Mid-stream reset: with entries queued on ports 0 and 2 and out_valid=1, assert reset for 1 cycle. Expect all outputs 0 on the next cycle and no stale entries afterwards. The next event on port 1 is output with out_port=1.
